modrm_operand_fetch: RTL and testbench

//  Parametrised ModR/M decode and operand-fetch engine for the 8086-class core.
//  The core hands over a start request with its register/segment snapshot and current IP.
//  The block reads the ModR/M byte and any displacement from the code stream, then forms EA and the segment.
//  It fetches a byte or multi-byte memory operand little-endian over the shared 8-bit bus, returns op1/op2 and the new IP,
//  and optionally writes a result back to the same EA.

---
 rtl/modrm_operand_fetch_if.sv | 24 ++
 rtl/modrm_operand_fetch.sv | 268 ++++++++++++++++++++++++++
 tb/tb_modrm_operand_fetch.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/modrm_operand_fetch_if.sv
// Bus and request/response handshake between the ModR/M operand-fetch engine and the core/memory.
// The engine side (master) drives the address/write strobe and the busy/done status.
interface modrm_operand_fetch_if #(
    parameter int ADDR_W = 20
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_ready;
    logic [7:0]        bus;
    logic [ADDR_W-1:0] address;
    logic [7:0]        data;
    logic              wreq;

    modport master (
        input  start, mem_ready, bus,
        output busy, done, address, data, wreq
    );

    modport slave (
        output start, mem_ready, bus,
        input  busy, done, address, data, wreq
    );
endinterface

// File: rtl/modrm_operand_fetch.sv
// ModR/M decode and operand-fetch engine: reads ModR/M + displacement, forms EA/segment, fetches the r/m operand.
// Optional result write-back to the same EA is built when MEM_WRITEBACK_EN is defined.
module modrm_operand_fetch #(
    parameter int OP_W   = 16,
    parameter int ADDR_W = 20
) (
    input  logic                clock,
    input  logic                reset,
    modrm_operand_fetch_if.master fif,
    input  logic                isize,
    input  logic                idir,
    input  logic [8*OP_W-1:0]   regs,
    input  logic [15:0]         seg_cs,
    input  logic [15:0]         seg_ds,
    input  logic [15:0]         seg_ss,
    input  logic [15:0]         seg_es,
    input  logic                seg_ovr_vld,
    input  logic [15:0]         seg_ovr,
    input  logic [15:0]         ip_in,
    output logic [7:0]          modrm,
    output logic [OP_W-1:0]     op1,
    output logic [OP_W-1:0]     op2,
    output logic [15:0]         ea,
    output logic [15:0]         seg_ea,
    output logic [15:0]         ip_out
`ifdef MEM_WRITEBACK_EN
    ,
    input  logic                wb_start,
    input  logic [OP_W-1:0]     wb_data,
    output logic                wb_done
`endif
);

    localparam int NB = OP_W / 8;
    localparam int KW = $clog2(NB) + 1;
    localparam int PW = (ADDR_W > 20) ? ADDR_W : 20;

    typedef enum logic [2:0] {
        S_IDLE, S_MODRM, S_DISP_LO, S_DISP_HI, S_DISP8, S_MEM_RD, S_DONE, S_WB
    } state_t;

    state_t state, state_nx;

    logic                isize_q, idir_q, seg_ovr_vld_q;
    logic [8*OP_W-1:0]   regs_q;
    logic [15:0]         seg_cs_q, seg_ds_q, seg_ss_q, seg_es_q, seg_ovr_q;
    logic [7:0]          disp_lo;
    logic [KW-1:0]       k;
    logic [KW-1:0]       k_last;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_c;

    logic [1:0]          b_mod;
    logic [2:0]          b_reg, b_rm;
    logic                b_direct, b_use_ss;
    logic [OP_W-1:0]     b_regop, b_rmreg;

    function automatic logic [ADDR_W-1:0] phys(input logic [15:0] seg, input logic [15:0] off);
        logic [PW-1:0] sum;
        sum = PW'({seg, 4'h0}) + PW'(off);
        return sum[ADDR_W-1:0];
    endfunction

    function automatic logic [15:0] reg16(input logic [8*OP_W-1:0] r, input int idx);
        return r[idx*OP_W +: 16];
    endfunction

    // Byte registers: 0-3 are the low bytes of AX..BX, 4-7 the high bytes of the same four.
    function automatic logic [OP_W-1:0] reg_operand(input logic [8*OP_W-1:0] r,
                                                    input logic [2:0] n, input logic sz);
        int idx;
        idx = int'(n);
        if (sz)
            return r[idx*OP_W +: OP_W];
        else if (idx < 4)
            return OP_W'(r[idx*OP_W +: 8]);
        else
            return OP_W'(r[(idx-4)*OP_W + 8 +: 8]);
    endfunction

    function automatic logic [15:0] ea_base(input logic [8*OP_W-1:0] r, input logic [2:0] rm);
        case (rm)
            3'd0:    return reg16(r, 3) + reg16(r, 6);
            3'd1:    return reg16(r, 3) + reg16(r, 7);
            3'd2:    return reg16(r, 5) + reg16(r, 6);
            3'd3:    return reg16(r, 5) + reg16(r, 7);
            3'd4:    return reg16(r, 6);
            3'd5:    return reg16(r, 7);
            3'd6:    return reg16(r, 5);
            default: return reg16(r, 3);
        endcase
    endfunction

    function automatic logic [OP_W-1:0] set_byte(input logic [OP_W-1:0] v, input int idx,
                                                 input logic [7:0] b);
        logic [OP_W-1:0] t;
        t = v;
        t[idx*8 +: 8] = b;
        return t;
    endfunction

    function automatic logic [7:0] get_byte(input logic [OP_W-1:0] v, input int idx);
        return v[idx*8 +: 8];
    endfunction

    assign b_mod    = fif.bus[7:6];
    assign b_reg    = fif.bus[5:3];
    assign b_rm     = fif.bus[2:0];
    assign b_direct = (b_mod == 2'b00) && (b_rm == 3'b110);
    assign b_use_ss = (b_rm == 3'b010) || (b_rm == 3'b011) ||
                      ((b_rm == 3'b110) && (b_mod != 2'b00));
    assign b_regop  = reg_operand(regs_q, b_reg, isize_q);
    assign b_rmreg  = reg_operand(regs_q, b_rm, isize_q);
    assign k_last   = isize_q ? KW'(NB - 1) : '0;

    assign fif.busy    = (state != S_IDLE);
    assign fif.done    = done_q;
    assign fif.address = addr_c;

`ifdef MEM_WRITEBACK_EN
    logic [OP_W-1:0] wb_q;
    logic            wb_ok;

    assign fif.wreq  = (state == S_WB);
    assign fif.data  = (state == S_WB) ? get_byte(wb_q, int'(k)) : 8'h00;
    assign wb_done   = (state == S_WB) && fif.mem_ready && (k == k_last);
`else
    assign fif.wreq  = 1'b0;
    assign fif.data  = 8'h00;
`endif

    always_comb begin
        state_nx = state;
        addr_c   = '0;
        case (state)
            S_IDLE: begin
                if (fif.start)
                    state_nx = S_MODRM;
`ifdef MEM_WRITEBACK_EN
                else if (wb_start && wb_ok)
                    state_nx = S_WB;
`endif
            end
            S_MODRM: begin
                addr_c = phys(seg_cs_q, ip_out);
                if (fif.mem_ready) begin
                    case (b_mod)
                        2'b00:   state_nx = b_direct ? S_DISP_LO : S_MEM_RD;
                        2'b01:   state_nx = S_DISP8;
                        2'b10:   state_nx = S_DISP_LO;
                        default: state_nx = S_DONE;
                    endcase
                end
            end
            S_DISP_LO: begin
                addr_c = phys(seg_cs_q, ip_out);
                if (fif.mem_ready) state_nx = S_DISP_HI;
            end
            S_DISP_HI, S_DISP8: begin
                addr_c = phys(seg_cs_q, ip_out);
                if (fif.mem_ready) state_nx = S_MEM_RD;
            end
            S_MEM_RD: begin
                addr_c = phys(seg_ea, ea + 16'(k));
                if (fif.mem_ready && (k == k_last)) state_nx = S_DONE;
            end
            S_DONE: begin
                if (fif.mem_ready) state_nx = S_IDLE;
            end
            S_WB: begin
                addr_c = phys(seg_ea, ea + 16'(k));
                if (fif.mem_ready && (k == k_last)) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Request snapshot: only consumed after the start cycle, so it needs no reset.
    always_ff @(posedge clock) begin
        if ((state == S_IDLE) && fif.start) begin
            isize_q       <= isize;
            idir_q        <= idir;
            regs_q        <= regs;
            seg_cs_q      <= seg_cs;
            seg_ds_q      <= seg_ds;
            seg_ss_q      <= seg_ss;
            seg_es_q      <= seg_es;
            seg_ovr_vld_q <= seg_ovr_vld;
            seg_ovr_q     <= seg_ovr;
        end
        if ((state == S_DISP_LO) && fif.mem_ready)
            disp_lo <= fif.bus;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            k      <= '0;
            done_q <= 1'b0;
            modrm  <= '0;
            op1    <= '0;
            op2    <= '0;
            ea     <= '0;
            seg_ea <= '0;
            ip_out <= '0;
`ifdef MEM_WRITEBACK_EN
            wb_ok  <= 1'b0;
            wb_q   <= '0;
`endif
        end else begin
            state  <= state_nx;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    k <= '0;
                    if (fif.start) begin
                        ip_out <= ip_in;
`ifdef MEM_WRITEBACK_EN
                        wb_ok  <= 1'b0;
                    end else if (wb_start && wb_ok) begin
                        wb_q   <= wb_data;
`endif
                    end
                end
                S_MODRM: if (fif.mem_ready) begin
                    modrm  <= fif.bus;
                    ip_out <= ip_out + 16'd1;
                    ea     <= b_direct ? 16'h0000 : ea_base(regs_q, b_rm);
                    seg_ea <= seg_ovr_vld_q ? seg_ovr_q : (b_use_ss ? seg_ss_q : seg_ds_q);
                    // The r/m side starts at zero so memory bytes can be merged in one at a time.
                    op1    <= idir_q ? b_regop : ((b_mod == 2'b11) ? b_rmreg : '0);
                    op2    <= idir_q ? ((b_mod == 2'b11) ? b_rmreg : '0) : b_regop;
                    done_q <= (b_mod == 2'b11);
                end
                S_DISP_LO: if (fif.mem_ready) begin
                    ip_out <= ip_out + 16'd1;
                end
                S_DISP_HI: if (fif.mem_ready) begin
                    ip_out <= ip_out + 16'd1;
                    ea     <= ea + {fif.bus, disp_lo};
                end
                S_DISP8: if (fif.mem_ready) begin
                    ip_out <= ip_out + 16'd1;
                    ea     <= ea + {{8{fif.bus[7]}}, fif.bus};
                end
                S_MEM_RD: if (fif.mem_ready) begin
                    if (idir_q)
                        op2 <= set_byte(op2, int'(k), fif.bus);
                    else
                        op1 <= set_byte(op1, int'(k), fif.bus);
                    k      <= k + 1'b1;
                    done_q <= (k == k_last);
                end
                S_DONE: begin
`ifdef MEM_WRITEBACK_EN
                    if (fif.mem_ready)
                        wb_ok <= (modrm[7:6] != 2'b11);
`endif
                end
                S_WB: if (fif.mem_ready) begin
                    k <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modrm_operand_fetch.sv
// Table-driven bench for modrm_operand_fetch with a byte-array memory model and an expected-result queue.
// Write-back sequence is included when MEM_WRITEBACK_EN is defined.
module tb_modrm_operand_fetch;
    localparam int OP_W   = 16;
    localparam int ADDR_W = 20;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    modrm_operand_fetch_if #(.ADDR_W(ADDR_W)) fif ();

    logic                isize, idir, seg_ovr_vld;
    logic [8*OP_W-1:0]   regs;
    logic [15:0]         seg_cs, seg_ds, seg_ss, seg_es, seg_ovr, ip_in;
    logic [7:0]          modrm;
    logic [OP_W-1:0]     op1, op2;
    logic [15:0]         ea, seg_ea, ip_out;
`ifdef MEM_WRITEBACK_EN
    logic                wb_start;
    logic [OP_W-1:0]     wb_data;
    logic                wb_done;
`endif

    modrm_operand_fetch #(.OP_W(OP_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .fif(fif),
        .isize(isize), .idir(idir), .regs(regs),
        .seg_cs(seg_cs), .seg_ds(seg_ds), .seg_ss(seg_ss), .seg_es(seg_es),
        .seg_ovr_vld(seg_ovr_vld), .seg_ovr(seg_ovr), .ip_in(ip_in),
        .modrm(modrm), .op1(op1), .op2(op2), .ea(ea), .seg_ea(seg_ea), .ip_out(ip_out)
`ifdef MEM_WRITEBACK_EN
        , .wb_start(wb_start), .wb_data(wb_data), .wb_done(wb_done)
`endif
    );

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    assign fif.bus = mem[fif.address];

    typedef struct {
        logic [15:0] ip;
        logic [7:0]  c0, c1, c2;
        logic        ovr_vld;
        logic [15:0] ovr;
        logic        sz, dir;
        logic [19:0] ma0; logic [7:0] md0;
        logic [19:0] ma1; logic [7:0] md1;
        logic [15:0] e_op1, e_op2, e_ea, e_seg, e_ip;
        logic        chk_ea;
        int          lat;
    } vec_t;

    typedef struct {
        logic [7:0]  modrm;
        logic [15:0] op1, op2, ea, seg, ip;
        logic        chk_ea;
        int          lat;
    } exp_t;

    vec_t vt [10];
    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;
    bit   stall = 1'b0;

    logic [19:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    int          wbd_cnt = 0;

    localparam logic [8*OP_W-1:0] REGS0 =
        {16'h0200, 16'h0100, 16'h0010, 16'hFFFE, 16'h5678, 16'hDD02, 16'hCC01, 16'h1234};

    always @(posedge clock) begin
        if (fif.wreq && fif.mem_ready) begin
            wr_addr.push_back(fif.address);
            wr_data.push_back(fif.data);
        end
`ifdef MEM_WRITEBACK_EN
        if (wb_done) wbd_cnt++;
`endif
    end

    initial begin
        fif.mem_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (stall) fif.mem_ready = ~fif.mem_ready;
            else       fif.mem_ready = 1'b1;
        end
    end

    function automatic logic [19:0] phys(input logic [15:0] seg, input logic [15:0] off);
        return {seg, 4'h0} + {4'h0, off};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit stl, input int id);
        exp_t e;
        exp_t got;
        int   cyc;
        mem[phys(seg_cs, v.ip)]         = v.c0;
        mem[phys(seg_cs, v.ip + 16'd1)] = v.c1;
        mem[phys(seg_cs, v.ip + 16'd2)] = v.c2;
        mem[v.ma0] = v.md0;
        mem[v.ma1] = v.md1;
        ip_in = v.ip; isize = v.sz; idir = v.dir;
        seg_ovr_vld = v.ovr_vld; seg_ovr = v.ovr;
        e = '{v.c0, v.e_op1, v.e_op2, v.e_ea, v.e_seg, v.e_ip, v.chk_ea, v.lat};
        sb.push_back(e);
        fif.start = 1'b1;
        @(posedge clock); #1;
        fif.start = 1'b0;
        cyc = 1;
        while (!fif.done && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        got = sb.pop_front();
        if (!fif.done) begin
            checks++; failures++;
            $display("FAIL v%0d_timeout actual=no_done required=done", id);
        end else begin
            check($sformatf("v%0d_modrm", id), modrm, got.modrm);
            check($sformatf("v%0d_op1", id), op1, got.op1);
            check($sformatf("v%0d_op2", id), op2, got.op2);
            check($sformatf("v%0d_ip_out", id), ip_out, got.ip);
            if (got.chk_ea) begin
                check($sformatf("v%0d_ea", id), ea, got.ea);
                check($sformatf("v%0d_seg_ea", id), seg_ea, got.seg);
            end
            if (!stl) check($sformatf("v%0d_latency", id), cyc, got.lat);
            @(posedge clock); #1;
            check($sformatf("v%0d_done_pulse", id), fif.done, 1'b0);
        end
        cyc = 0;
        while (fif.busy && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (fif.busy) begin
            checks++; failures++;
            $display("FAIL v%0d_idle actual=busy required=idle", id);
        end
    endtask

    initial begin
        vt[0] = '{16'h0100, 8'hD8, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0,
                  20'h00000, 8'h00, 20'h00000, 8'h00,
                  16'h1234, 16'h5678, 16'h0000, 16'h0000, 16'h0101, 1'b0, 2};
        vt[1] = '{16'h0100, 8'h06, 8'h34, 8'h12, 1'b0, 16'h0000, 1'b1, 1'b1,
                  20'h21234, 8'hAA, 20'h21235, 8'hBB,
                  16'h1234, 16'hBBAA, 16'h1234, 16'h2000, 16'h0103, 1'b1, 6};
        vt[2] = '{16'h0100, 8'h46, 8'hFE, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1,
                  20'h3000E, 8'h5C, 20'h3000F, 8'h77,
                  16'h0034, 16'h005C, 16'h000E, 16'h3000, 16'h0102, 1'b1, 4};
        vt[3] = '{16'h0100, 8'h42, 8'h00, 8'h00, 1'b1, 16'h4000, 1'b1, 1'b0,
                  20'h40110, 8'h11, 20'h40111, 8'h22,
                  16'h2211, 16'h1234, 16'h0110, 16'h4000, 16'h0102, 1'b1, 5};
        vt[4] = '{16'h0100, 8'h8F, 8'h00, 8'h80, 1'b0, 16'h0000, 1'b0, 1'b0,
                  20'h2D678, 8'h9E, 20'h2D679, 8'h66,
                  16'h009E, 16'h0001, 16'hD678, 16'h2000, 16'h0103, 1'b1, 5};
        vt[5] = '{16'h0100, 8'hE6, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1,
                  20'h00000, 8'h00, 20'h00000, 8'h00,
                  16'h0012, 16'h00DD, 16'h0000, 16'h0000, 16'h0101, 1'b0, 2};
        vt[6] = '{16'h0100, 8'h1A, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b1,
                  20'h30110, 8'h33, 20'h30111, 8'h44,
                  16'h5678, 16'h4433, 16'h0110, 16'h3000, 16'h0101, 1'b1, 4};
        vt[7] = '{16'h0100, 8'h87, 8'h87, 8'hA9, 1'b0, 16'h0000, 1'b1, 1'b0,
                  20'h2FFFF, 8'hC3, 20'h20000, 8'hD4,
                  16'hD4C3, 16'h1234, 16'hFFFF, 16'h2000, 16'h0103, 1'b1, 6};
        vt[8] = '{16'hFFFF, 8'hC0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0,
                  20'h00000, 8'h00, 20'h00000, 8'h00,
                  16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2};
        vt[9] = '{16'hFFFF, 8'h06, 8'h78, 8'h56, 1'b0, 16'h0000, 1'b1, 1'b0,
                  20'h25678, 8'h9A, 20'h25679, 8'hBC,
                  16'hBC9A, 16'h1234, 16'h5678, 16'h2000, 16'h0002, 1'b1, 6};

        regs = REGS0;
        seg_cs = 16'h1000; seg_ds = 16'h2000; seg_ss = 16'h3000; seg_es = 16'h4000;
        seg_ovr = 16'h0000; seg_ovr_vld = 1'b0; ip_in = 16'h0000;
        isize = 1'b0; idir = 1'b0; fif.start = 1'b0;
`ifdef MEM_WRITEBACK_EN
        wb_start = 1'b0; wb_data = '0;
`endif
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_busy", fif.busy, 1'b0);
        check("rst_done", fif.done, 1'b0);
        check("rst_op1", op1, 16'h0000);
        check("rst_op2", op2, 16'h0000);
        check("rst_ea", ea, 16'h0000);
        check("rst_ip_out", ip_out, 16'h0000);
        check("rst_address", fif.address, 20'h00000);

        for (int i = 0; i < 10; i++) run_vec(vt[i], 1'b0, i);
        stall = 1'b1;
        for (int i = 0; i < 10; i++) run_vec(vt[i], 1'b1, 10 + i);
        stall = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Abort in the middle of the data read.
        mem[phys(seg_cs, 16'h0100)] = 8'h06;
        mem[phys(seg_cs, 16'h0101)] = 8'h34;
        mem[phys(seg_cs, 16'h0102)] = 8'h12;
        ip_in = 16'h0100; isize = 1'b1; idir = 1'b1; seg_ovr_vld = 1'b0;
        fif.start = 1'b1;
        @(posedge clock); #1;
        fif.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("mid_busy", fif.busy, 1'b1);
        check("mid_address", fif.address, 20'h21234);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_busy", fif.busy, 1'b0);
        check("abort_op1", op1, 16'h0000);
        check("abort_ip_out", ip_out, 16'h0000);
        check("abort_modrm", modrm, 8'h00);
        check("abort_wreq", fif.wreq, 1'b0);

        run_vec(vt[1], 1'b0, 20);

`ifdef MEM_WRITEBACK_EN
        begin
            vec_t w;
            int   cyc;
            regs[3*OP_W +: OP_W] = 16'hFFFF;
            w = '{16'h0100, 8'h07, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0,
                  20'h2FFFF, 8'hC3, 20'h20000, 8'hD4,
                  16'hD4C3, 16'h1234, 16'hFFFF, 16'h2000, 16'h0101, 1'b1, 4};
            run_vec(w, 1'b0, 30);
            wb_data  = 16'hA1B2;
            wb_start = 1'b1;
            @(posedge clock); #1;
            wb_start = 1'b0;
            cyc = 0;
            while (fif.busy && cyc < 50) begin
                @(posedge clock); #1;
                cyc++;
            end
            check("wb_count", wr_addr.size(), 2);
            if (wr_addr.size() == 2) begin
                check("wb_addr0", wr_addr[0], 20'h2FFFF);
                check("wb_data0", wr_data[0], 8'hB2);
                check("wb_addr1", wr_addr[1], 20'h20000);
                check("wb_data1", wr_data[1], 8'hA1);
            end
            check("wb_done_count", wbd_cnt, 1);
            regs = REGS0;
        end
`else
        check("no_write", wr_addr.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
